sr_flag_arbiter: RTL and testbench
==================================

# sr_flag_arbiter

Shared-access controller for a bank of NFLAG positive-edge SR flip-flops used as status flags. It arbitrates set/clear requests from NREQ requesters round-robin and drives one-cycle s/r pulses into the bank. The encoding guarantees the illegal s=r=1 combination never reaches a flop. It reads each affected flop's q back one cycle after the pulse and flags any flop that did not take the commanded value.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- NFLAG, 8, number of SR flip-flops in the bank (2..32)
- IDXW, $clog2(NFLAG), flag index width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  NREQ  request pending, one bit per requester
- req_op  input  NREQ  per requester: 1 = set, 0 = clear
- req_idx  input  NREQ*IDXW  per-requester flag index; requester k uses bits [k*IDXW +: IDXW]
- req_ready  output  NREQ  grant; a transfer occurs on a cycle with req_valid[k] & req_ready[k]
- clr_all  input  1  request to clear every flag in the bank
- clr_all_ack  output  1  one-cycle pulse when clr_all is accepted
- s_out  output  NFLAG  set lines to the flop bank, registered
- r_out  output  NFLAG  reset lines to the flop bank, registered
- q_in  input  NFLAG  q outputs of the flop bank
- busy  output  1  high in any state other than IDLE
- err  output  1  one-cycle pulse on a readback mismatch
- err_idx  output  IDXW  index of the failing flag; holds its value until the next err (all-ones for a clr_all failure)

## Operation
- The FSM has three states: IDLE, ISSUE and VERIFY. Sequence is IDLE -> ISSUE -> VERIFY -> IDLE, unconditionally after acceptance.
- Arbitration happens only in IDLE:
  - clr_all has priority over all req_valid.
  - Otherwise the winner is the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
- req_ready (combinational, one-hot or zero):
  - Equals the winner bit in IDLE.
  - Is 0 in ISSUE and VERIFY, and 0 while rst is low.
- On acceptance the block latches op, idx and winner id, and sets rr_ptr to (id+1) mod NREQ.
- clr_all acceptance pulses clr_all_ack and leaves rr_ptr unchanged.
- ISSUE behaviour:
  - Exactly one s/r pulse is driven for the cycle.
  - Set: s_out[idx]=1, r_out=0.
  - Clear: r_out[idx]=1, s_out=0.
  - clr_all: r_out = all ones, s_out=0.
  - All other bits are 0. s_out & r_out is 0 on every cycle.
- VERIFY compares q_in[idx] against op, or q_in against 0 for clr_all.
  - On mismatch: err=1 for that cycle and err_idx is updated.
  - s_out and r_out are 0 in VERIFY.
- req_idx >= NFLAG is accepted and treated as a no-op: no pulse is driven and VERIFY is skipped (ISSUE -> IDLE).
- A set to an already-set flag, or a clear to a clear flag, is issued normally.
- Dropping req_valid while not granted is allowed, with no side effect.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - State = IDLE, rr_ptr = 0.
  - s_out, r_out, err, clr_all_ack = 0; err_idx = 0; busy = 0.
  - Outputs clear immediately on rst falling, without waiting for clk.
- Grant at edge T (valid & ready): s_out/r_out are high during cycle T+1 (ISSUE). The flop captures at edge T+2, and q_in is compared during cycle T+2 (VERIFY).
- The next grant can occur in cycle T+3. Sustained throughput is 1 request per 3 cycles.
- busy is high during T+1 and T+2.
- Reset mid-ISSUE or mid-VERIFY: the s/r pulse is cut immediately and the in-flight request is lost. No second handshake is issued and no err is raised.
- A requester that holds req_valid and changes req_op/req_idx before its grant is served with the values present in its grant cycle.
- When clr_all and req_valid are both high in IDLE, clr_all wins. The requester keeps waiting and is served in the next IDLE cycle if still valid.

## Test plan
- Single set: NREQ=4, req_valid=0001, req_op[0]=1, idx=3. Required: ready[0] in cycle 0, s_out=0x08 in cycle 1, q_in[3]=1 in cycle 2, err stays 0, busy high for cycles 1-2.
- Round-robin fairness: all four req_valid held high. Grant order must be 0,1,2,3,0, with grants spaced 3 cycles apart and rr_ptr wrapping from 3 to 0.
- Priority collision: clr_all=1 and req_valid=0100 in the same IDLE cycle. Required: clr_all_ack, then r_out=0xFF for one cycle, then requester 2 granted in the following IDLE cycle; no cycle has any bit with s_out & r_out.
- Readback fault: model flag 5 stuck at 0 and issue set idx=5. Required: err pulses in the VERIFY cycle, err_idx=5 and holds; a later good request leaves err_idx=5 and err=0.
- Out-of-range index: NFLAG=8, req_idx=9. Required: ready asserted, s_out=r_out=0 throughout, back in IDLE after 2 cycles, no err.
- Reset mid-op: assert rst low during ISSUE of set idx=2. Required: s_out goes 0 without a clk edge; after release all outputs are 0 and the requester is not re-granted unless it re-asserts req_valid.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// rtl/sr_flag_arbiter.sv - round-robin set/clear arbiter for a bank of SR flag flops with readback check
//
// Purpose: grants one requester (or a bank-wide clear) at a time, drives a single
// registered s/r pulse into the flop bank, then verifies the flop took the value.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   req_valid/op/idx  per-requester request, 1=set 0=clear, flag index (packed IDXW each)
//   req_ready         combinational one-hot grant, only in IDLE
//   clr_all/_ack      clear-every-flag request and its one-cycle acceptance pulse
//   s_out, r_out      registered set/reset lines to the bank, never both high on a bit
//   q_in              flop bank outputs
//   busy              high outside IDLE
//   err, err_idx      readback mismatch pulse and sticky failing index (all-ones for clr_all)

module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_op,
  input  logic [NREQ*IDXW-1:0] req_idx,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clr_all,
  output logic                 clr_all_ack,
  output logic [NFLAG-1:0]     s_out,
  output logic [NFLAG-1:0]     r_out,
  input  logic [NFLAG-1:0]     q_in,
  output logic                 busy,
  output logic                 err,
  output logic [IDXW-1:0]      err_idx
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, VERIFY} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               op_q, op_d;
  logic               clr_q, clr_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [NFLAG-1:0]   s_q, s_d, r_q, r_d;
  logic [IDXW-1:0]    err_idx_q, err_idx_d;

  logic               win_found;
  logic [PW-1:0]      win_id;
  logic               win_op;
  logic [IDXW-1:0]    win_idx;
  logic               accept_clr, accept_req;
  logic               mismatch;
  logic [IDXW-1:0]    fail_idx;

  // One-hot decode of a flag index; out-of-range indices decode to zero, which
  // is what turns them into a no-op pulse.
  function automatic logic [NFLAG-1:0] flag_dec(input logic [IDXW-1:0] i);
    flag_dec = '0;
    for (int f = 0; f < NFLAG; f++) begin
      if (i == IDXW'(f)) flag_dec[f] = 1'b1;
    end
  endfunction

  // Round-robin search starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin : arb_search
    int k;
    win_found = 1'b0;
    win_id    = '0;
    win_op    = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(rr_ptr_q) + off) % NREQ;
      if (!win_found && req_valid[k]) begin
        win_found = 1'b1;
        win_id    = PW'(k);
        win_op    = req_op[k];
        win_idx   = req_idx[k*IDXW +: IDXW];
      end
    end
  end

  assign accept_clr = rst && (state_q == IDLE) && clr_all;
  assign accept_req = rst && (state_q == IDLE) && !clr_all && win_found;

  always_comb begin
    req_ready = '0;
    if (accept_req) req_ready[win_id] = 1'b1;
  end

  assign clr_all_ack = accept_clr;

  // Readback: bank-wide clear expects every q low, otherwise the addressed q
  // must equal the commanded op.
  assign mismatch = clr_q ? (|q_in) : ((|(q_in & flag_dec(idx_q))) != op_q);
  assign fail_idx = clr_q ? {IDXW{1'b1}} : idx_q;
  assign err      = (state_q == VERIFY) && mismatch;
  assign err_idx  = err ? fail_idx : err_idx_q;
  assign err_idx_d = err ? fail_idx : err_idx_q;

  assign busy  = (state_q != IDLE);
  assign s_out = s_q;
  assign r_out = r_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    clr_d    = clr_q;
    idx_d    = idx_q;
    s_d      = '0;
    r_d      = '0;
    case (state_q)
      IDLE: begin
        if (accept_clr) begin
          state_d = ISSUE;
          clr_d   = 1'b1;
          op_d    = 1'b0;
          r_d     = '1;
        end else if (accept_req) begin
          state_d  = ISSUE;
          clr_d    = 1'b0;
          op_d     = win_op;
          idx_d    = win_idx;
          rr_ptr_d = (win_id == PW'(NREQ - 1)) ? '0 : win_id + 1'b1;
          // Set and clear target disjoint vectors, so s&r can never overlap.
          if (win_op) s_d = flag_dec(win_idx);
          else        r_d = flag_dec(win_idx);
        end
      end
      ISSUE: begin
        // Out-of-range requests drove no pulse, so there is nothing to verify.
        state_d = (clr_q || (|flag_dec(idx_q))) ? VERIFY : IDLE;
      end
      VERIFY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      op_q      <= 1'b0;
      clr_q     <= 1'b0;
      idx_q     <= '0;
      s_q       <= '0;
      r_q       <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      op_q      <= op_d;
      clr_q     <= clr_d;
      idx_q     <= idx_d;
      s_q       <= s_d;
      r_q       <= r_d;
      err_idx_q <= err_idx_d;
    end
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb/tb_sr_flag_arbiter.sv - self-checking bench for sr_flag_arbiter against a timeline reference model

module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req_valid;
  logic [3:0]       req_op;
  logic [15:0]      req_idx;
  logic [3:0]       req_ready;
  logic             clr_all;
  logic             clr_all_ack;
  logic [7:0]       s_out;
  logic [7:0]       r_out;
  logic [7:0]       q_in;
  logic             busy;
  logic             err;
  logic [3:0]       err_idx;

  logic [7:0]       bank = '0;
  logic [7:0]       stuck0 = '0;
  logic [7:0]       stuck1 = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int         m_busy = 0;
  int         m_ver  = 0;
  int         m_rr   = 0;
  logic [7:0] m_ps   = '0;
  logic [7:0] m_pr   = '0;
  logic [7:0] m_flag = '0;
  logic       m_ver_clr = 1'b0;
  logic       m_ver_op  = 1'b0;
  int         m_ver_idx = 0;
  logic [3:0] m_hold = '0;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx), .req_ready(req_ready),
    .clr_all(clr_all), .clr_all_ack(clr_all_ack),
    .s_out(s_out), .r_out(r_out), .q_in(q_in),
    .busy(busy), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;

  // Behavioural SR flop bank; stuck masks model broken flops on the q side.
  always @(posedge clk) bank <= (bank | s_out) & ~r_out;
  assign q_in = (bank | stuck1) & ~stuck0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ver = 0; m_rr = 0; m_ps = '0; m_pr = '0; m_hold = '0;
  endtask

  // One clock cycle: drive inputs, predict every output from the model, compare, advance model.
  task automatic cycle(input logic [3:0] v, input logic [3:0] op, input logic [15:0] idx, input logic clr);
    logic [3:0] e_ready;
    logic       e_ack;
    logic       e_err;
    logic [3:0] e_eidx;
    logic [3:0] fidx;
    logic [7:0] eq;
    int         win;
    int         ix;
    @(posedge clk); #1;
    req_valid = v; req_op = op; req_idx = idx; clr_all = clr;
    #3;
    e_ack = (m_busy == 0) && clr;
    win = -1;
    if (m_busy == 0 && !clr) begin
      for (int o = 0; o < NREQ; o++) begin
        int k = (m_rr + o) % NREQ;
        if (win < 0 && v[k]) win = k;
      end
    end
    e_ready = (win >= 0) ? 4'(1 << win) : 4'b0;
    eq = (m_flag | stuck1) & ~stuck0;
    fidx = m_ver_clr ? 4'hF : 4'(m_ver_idx);
    e_err = 1'b0;
    if (m_ver == 1) e_err = m_ver_clr ? (eq != 8'h00) : (eq[m_ver_idx] != m_ver_op);
    e_eidx = e_err ? fidx : m_hold;

    check_eq("req_ready", 32'(req_ready), 32'(e_ready));
    check_eq("clr_all_ack", 32'(clr_all_ack), 32'(e_ack));
    check_eq("s_out", 32'(s_out), 32'(m_ps));
    check_eq("r_out", 32'(r_out), 32'(m_pr));
    check_eq("s_and_r", 32'(s_out & r_out), 32'h0);
    check_eq("busy", 32'(busy), 32'(m_busy > 0));
    check_eq("err", 32'(err), 32'(e_err));
    check_eq("err_idx", 32'(err_idx), 32'(e_eidx));

    if (e_err) m_hold = fidx;
    m_flag = (m_flag | m_ps) & ~m_pr;
    m_ps = '0; m_pr = '0;
    if (m_busy > 0) m_busy--;
    if (m_ver > 0) m_ver--;
    if (e_ack) begin
      m_pr = 8'hFF; m_busy = 2; m_ver = 2; m_ver_clr = 1'b1;
    end else if (win >= 0) begin
      ix = int'(idx[win*4 +: 4]);
      m_rr = (win + 1) % NREQ;
      m_ver_clr = 1'b0; m_ver_op = op[win]; m_ver_idx = ix;
      if (ix < NFLAG) begin
        if (op[win]) m_ps = 8'(1 << ix);
        else         m_pr = 8'(1 << ix);
        m_busy = 2; m_ver = 2;
      end else begin
        m_busy = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(4'b0, 4'b0, 16'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 4'hF; req_op = 4'hF; req_idx = 16'h0; clr_all = 1'b1;
    #2;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_ack", 32'(clr_all_ack), 32'h0);
    check_eq("rst_s", 32'(s_out), 32'h0);
    check_eq("rst_r", 32'(r_out), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    check_eq("rst_err_idx", 32'(err_idx), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    req_valid = 4'h0; clr_all = 1'b0;
    rst = 1'b1;

    // single set of flag 3 by requester 0
    cycle(4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd3}, 1'b0);
    idle(3);

    // round-robin with all requesters held
    for (int i = 0; i < 15; i++)
      cycle(4'b1111, 4'($urandom), {4'($urandom_range(0,7)), 4'($urandom_range(0,7)),
                                    4'($urandom_range(0,7)), 4'($urandom_range(0,7))}, 1'b0);
    idle(2);

    // clr_all collides with requester 2
    cycle(4'b0100, 4'b0100, {4'd0, 4'd6, 4'd0, 4'd0}, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b0100, 4'b0100, {4'd0, 4'd6, 4'd0, 4'd0}, 1'b0);
    idle(3);

    // flag 5 stuck at 0, then a good request must leave err_idx at 5
    stuck0 = 8'h20;
    cycle(4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd5}, 1'b0);
    idle(3);
    stuck0 = 8'h00;
    cycle(4'b0010, 4'b0010, {4'd0, 4'd0, 4'd3, 4'd0}, 1'b0);
    idle(3);

    // out-of-range index 9 is a no-op
    cycle(4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, 1'b0);
    idle(3);

    // flag 1 stuck at 1 breaks a bank-wide clear: err_idx all ones
    stuck1 = 8'h02;
    cycle(4'b0000, 4'b0000, 16'h0, 1'b1);
    idle(3);
    stuck1 = 8'h00;

    // reset during ISSUE of set flag 2
    cycle(4'b0001, 4'b0001, {4'd0, 4'd0, 4'd0, 4'd2}, 1'b0);
    @(posedge clk); #1;
    req_valid = 4'b0;
    #1;
    check_eq("issue_s_live", 32'(s_out), 32'h04);
    rst = 1'b0;
    #1;
    check_eq("midrst_s", 32'(s_out), 32'h0);
    check_eq("midrst_r", 32'(r_out), 32'h0);
    check_eq("midrst_busy", 32'(busy), 32'h0);
    req_valid = 4'hF;
    #1;
    check_eq("midrst_ready", 32'(req_ready), 32'h0);
    check_eq("midrst_err", 32'(err), 32'h0);
    req_valid = 4'h0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    idle(4);

    // randomized traffic, with occasional stuck flops
    for (int i = 0; i < 900; i++) begin
      if (i % 60 == 0) begin
        stuck0 = 8'($urandom & $urandom & $urandom);
        stuck1 = 8'($urandom & $urandom & $urandom) & ~stuck0;
        if (i % 120 == 0) begin stuck0 = '0; stuck1 = '0; end
      end
      cycle(4'($urandom), 4'($urandom), 16'($urandom), $urandom_range(0, 7) == 0);
    end
    stuck0 = '0; stuck1 = '0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
